// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int ZERO_REG = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus of the register file; slave side is the regfile.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(NREG);

  logic [NUM_WR-1:0]           we_i;
  logic [NUM_WR-1:0][AW-1:0]   waddr_i;
  logic [NUM_WR-1:0][XLEN-1:0] wdata_i;
  logic [NUM_RD-1:0][AW-1:0]   raddr_i;
  logic [NUM_RD-1:0][XLEN-1:0] rdata_o;
  logic [NUM_RD-1:0]           rbusy_o;
  logic                        alloc_i;
  logic [AW-1:0]               alloc_addr_i;
  logic                        flush_i;
  logic [NREG-1:0]             busy_o;

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, alloc_i, alloc_addr_i, flush_i,
    output rdata_o, rbusy_o, busy_o
  );
  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, alloc_i, alloc_addr_i, flush_i,
    input  rdata_o, rbusy_o, busy_o
  );
endinterface

// File: rtl/regfile_busy_sb.sv
// Pending-write scoreboard: one flag per register, set by alloc, cleared by write or flush.
module regfile_busy_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc,
  input  logic [AW-1:0]             alloc_addr,
  input  logic                      flush,
  input  logic [NUM_WR-1:0]         we,
  input  logic [NUM_WR-1:0][AW-1:0] waddr,
  input  logic [NUM_RD-1:0][AW-1:0] raddr,
  output logic [NREG-1:0]           busy,
  output logic [NUM_RD-1:0]         rbusy
);
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (we[w]) wr_hit[waddr[w]] = 1'b1;
  end

  // Priority: flush > alloc > write-clear; register 0 is never pending.
  always_comb begin
    busy_d = busy;
    for (int r = 1; r < NREG; r++) begin
      if (flush)                              busy_d[r] = 1'b0;
      else if (alloc && alloc_addr == AW'(r)) busy_d[r] = 1'b1;
      else if (wr_hit[r])                     busy_d[r] = 1'b0;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else        busy <= busy_d;

  // A same-cycle write makes the value available through the bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rbusy
    assign rbusy[k] = busy[raddr[k]] && !wr_hit[raddr[k]] &&
                      (raddr[k] != AW'(ZERO_REG));
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and pending-write scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs;

  // Ascending port order lets the higher-index port win on an address clash.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '0;
    else
      for (int w = 0; w < NUM_WR; w++)
        if (bus.we_i[w] && bus.waddr_i[w] != AW'(ZERO_REG))
          regs[bus.waddr_i[w]] <= bus.wdata_i[w];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [XLEN-1:0] rd;
    always_comb begin
      rd = regs[bus.raddr_i[k]];
      for (int w = 0; w < NUM_WR; w++)
        if (bus.we_i[w] && bus.waddr_i[w] == bus.raddr_i[k]) rd = bus.wdata_i[w];
      if (bus.raddr_i[k] == AW'(ZERO_REG)) rd = '0;
    end
    assign bus.rdata_o[k] = rd;
  end

  regfile_busy_sb #(
    .NREG(NREG), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .AW(AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (bus.alloc_i),
    .alloc_addr(bus.alloc_addr_i),
    .flush     (bus.flush_i),
    .we        (bus.we_i),
    .waddr     (bus.waddr_i),
    .raddr     (bus.raddr_i),
    .busy      (bus.busy_o),
    .rbusy     (bus.rbusy_o)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, write priority, reg 0, scoreboard, flush.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.we_i         = '0;
    bus.waddr_i      = '0;
    bus.wdata_i      = '0;
    bus.raddr_i      = '0;
    bus.alloc_i      = 1'b0;
    bus.alloc_addr_i = '0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.busy_o !== 32'h0) begin
      errors++; $display("FAIL reset_busy: got %h want 0", bus.busy_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 1; a < 32; a++) begin
      bus.raddr_i[0] = reg_addr_t'(a);
      bus.raddr_i[1] = reg_addr_t'(a);
      #1;
      checks++;
      if (bus.rdata_o[0] !== 32'h0 || bus.rdata_o[1] !== 32'h0 || bus.rbusy_o !== 2'b00) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h/%h rbusy %b want 0/0 rbusy 00",
                 a, bus.rdata_o[0], bus.rdata_o[1], bus.rbusy_o);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd5; bus.wdata_i[0] = 32'hA5A5A5A5;
    bus.raddr_i[1] = 5'd5; bus.raddr_i[0] = 5'd6;
    #1;
    checks++;
    if (bus.rdata_o[1] !== 32'hA5A5A5A5 || bus.rdata_o[0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_same: got %h/%h want A5A5A5A5/0", bus.rdata_o[1], bus.rdata_o[0]);
    end
    @(posedge clk); #1;
    bus.we_i = '0;
    #1;
    checks++;
    if (bus.rdata_o[1] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_next: got %h want A5A5A5A5", bus.rdata_o[1]);
    end
    idle();
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    bus.we_i = 2'b11;
    bus.waddr_i[0] = 5'd7; bus.wdata_i[0] = 32'h11;
    bus.waddr_i[1] = 5'd7; bus.wdata_i[1] = 32'h22;
    bus.raddr_i[0] = 5'd7; bus.raddr_i[1] = 5'd7;
    #1;
    checks++;
    if (bus.rdata_o[0] !== 32'h22 || bus.rdata_o[1] !== 32'h22) begin
      errors++;
      $display("FAIL same_addr_bypass: got %h/%h want 22/22", bus.rdata_o[0], bus.rdata_o[1]);
    end
    @(posedge clk); #1;
    bus.we_i = '0;
    #1;
    checks++;
    if (bus.rdata_o[0] !== 32'h22) begin
      errors++; $display("FAIL same_addr_stored: got %h want 22", bus.rdata_o[0]);
    end
    idle();
  endtask

  task automatic test_reg0();
    @(negedge clk);
    bus.we_i = 2'b11;
    bus.waddr_i[0] = 5'd0; bus.wdata_i[0] = 32'hFFFFFFFF;
    bus.waddr_i[1] = 5'd0; bus.wdata_i[1] = 32'hFFFFFFFF;
    bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd0;
    bus.raddr_i[0] = 5'd0;
    #1;
    checks++;
    if (bus.rdata_o[0] !== 32'h0 || bus.rbusy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reg0_bypass: got %h rbusy %b want 0 rbusy 0", bus.rdata_o[0], bus.rbusy_o[0]);
    end
    @(posedge clk); #1;
    idle();
    #1;
    checks++;
    if (bus.rdata_o[0] !== 32'h0 || bus.busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reg0_stored: got %h busy0 %b want 0 busy0 0", bus.rdata_o[0], bus.busy_o[0]);
    end
  endtask

  task automatic test_busy();
    @(negedge clk);
    bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd3;
    @(negedge clk);
    idle();
    bus.raddr_i[0] = 5'd3; bus.raddr_i[1] = 5'd4;
    #1;
    checks++;
    if (bus.rbusy_o !== 2'b01 || bus.busy_o !== 32'h8) begin
      errors++;
      $display("FAIL busy_set: got rbusy %b busy %h want 01 00000008", bus.rbusy_o, bus.busy_o);
    end
    bus.we_i[1] = 1'b1; bus.waddr_i[1] = 5'd3; bus.wdata_i[1] = 32'h33;
    #1;
    checks++;
    if (bus.rbusy_o[0] !== 1'b0 || bus.rdata_o[0] !== 32'h33) begin
      errors++;
      $display("FAIL busy_wr_same: got rbusy %b data %h want 0 33", bus.rbusy_o[0], bus.rdata_o[0]);
    end
    @(negedge clk);
    bus.we_i = '0;
    #1;
    checks++;
    if (bus.busy_o[3] !== 1'b0 || bus.rdata_o[0] !== 32'h33) begin
      errors++;
      $display("FAIL busy_clear: got busy3 %b data %h want 0 33", bus.busy_o[3], bus.rdata_o[0]);
    end
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd3; bus.wdata_i[0] = 32'h44;
    bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd3;
    @(negedge clk);
    idle();
    bus.raddr_i[0] = 5'd3;
    #1;
    checks++;
    if (bus.busy_o[3] !== 1'b1 || bus.rdata_o[0] !== 32'h44 || bus.rbusy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL alloc_wins: got busy3 %b data %h rbusy %b want 1 44 1",
               bus.busy_o[3], bus.rdata_o[0], bus.rbusy_o[0]);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd4;
    @(negedge clk);
    bus.alloc_addr_i = 5'd9;
    @(negedge clk);
    bus.alloc_i = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 32'h0000_0218) begin
      errors++; $display("FAIL flush_pre: got %h want 00000218", bus.busy_o);
    end
    bus.flush_i = 1'b1; bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd6;
    @(negedge clk);
    idle();
    bus.raddr_i[1] = 5'd7;
    #1;
    checks++;
    if (bus.busy_o !== 32'h0 || bus.rdata_o[1] !== 32'h22) begin
      errors++;
      $display("FAIL flush: got busy %h data7 %h want 0 22", bus.busy_o, bus.rdata_o[1]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.we_i[0] = 1'b1; bus.waddr_i[0] = 5'd8; bus.wdata_i[0] = 32'h88;
    bus.alloc_i = 1'b1; bus.alloc_addr_i = 5'd10;
    bus.raddr_i[1] = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rdata_o[1] !== 32'h0 || bus.busy_o !== 32'h0 || bus.rbusy_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_during: got data7 %h busy %h rbusy %b want 0 0 00",
               bus.rdata_o[1], bus.busy_o, bus.rbusy_o);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    bus.raddr_i[0] = 5'd8;
    #1;
    checks++;
    if (bus.rdata_o[0] !== 32'h0 || bus.busy_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got data8 %h busy %h want 0 0", bus.rdata_o[0], bus.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_same_addr();
    test_reg0();
    test_busy();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, number of architectural registers; power of two, min 2; address width AW = log2(NREG).
REQ-003 Parameter NUM_RD, default 2, number of read ports, 1..4.
REQ-004 Parameter NUM_WR, default 2, number of write ports, 1..2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 we_i  in  NUM_WR  per-port write enable.
REQ-008 waddr_i  in  NUM_WR x AW  per-port write address.
REQ-009 wdata_i  in  NUM_WR x XLEN  per-port write data.
REQ-010 raddr_i  in  NUM_RD x AW  per-port read address.
REQ-011 rdata_o  out  NUM_RD x XLEN  per-port read data, combinational.
REQ-012 rbusy_o  out  NUM_RD  per-port pending-write flag of the addressed register, combinational.
REQ-013 alloc_i  in  1  mark register alloc_addr_i as pending write.
REQ-014 alloc_addr_i  in  AW  register to mark pending.
REQ-015 flush_i  in  1  clear all pending flags.
REQ-016 busy_o  out  NREG  full pending-flag vector, registered.

Function
REQ-017 Register 0 SHALL always read 0, ignore writes, never be bypassed, never be marked busy.
REQ-018 On rising edge, each port with we_i=1 and waddr_i!=0 SHALL write wdata_i to waddr_i.
REQ-019 Two write ports to the same address in one cycle: the higher-index port SHALL win.
REQ-020 Read port SHALL return, in priority order: 0 if raddr_i=0; else wdata_i of the highest-index write port with we_i=1 and waddr_i=raddr_i (same-cycle bypass); else stored value.
REQ-021 Each read port SHALL compare against its own raddr_i only (no cross-port address mixing).
REQ-022 Write latency: data visible on rdata_o in the same cycle via bypass, in storage from the next cycle.
REQ-023 Busy flag of register r SHALL set on rising edge when alloc_i=1 and alloc_addr_i=r (r!=0).
REQ-024 Busy flag of r SHALL clear on rising edge when any write port writes r and no same-cycle alloc to r.
REQ-025 Simultaneous alloc and write to the same register: alloc wins, flag stays/becomes 1; data still written.
REQ-026 flush_i=1 SHALL clear all busy flags, overriding alloc_i in the same cycle; register data unaffected.
REQ-027 rbusy_o SHALL reflect busy flag of raddr_i, forced 0 when the same cycle writes raddr_i (bypass makes value ready); forced 0 for raddr_i=0.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all NREG registers (including the last) and all busy flags.
REQ-029 During reset rdata_o SHALL be 0 for non-bypassed reads, rbusy_o and busy_o 0; writes and allocs ignored.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight write of that edge.

Structure
REQ-031 Shared package SHALL hold XLEN default, register-address and register-data typedefs, ZERO_REG constant.
REQ-032 One sub-module regfile_busy_sb SHALL implement the busy scoreboard (REQ-023..027 state); storage and bypass stay in regfile_mp.

Verification
REQ-033 Reset, then read all ports addr 1..NREG-1 -> all data 0, busy_o=0 (including register NREG-1).
REQ-034 we0=1 waddr0=5 wdata0=0xA5A5A5A5, raddr1=5 same cycle -> rdata1=0xA5A5A5A5 same cycle and next cycle.
REQ-035 we0=we1=1, both waddr=7, wdata0=0x11, wdata1=0x22; read 7 -> 0x22 same cycle and after.
REQ-036 Write waddr=0 data 0xFFFFFFFF with alloc addr 0 -> read 0 returns 0, busy_o[0]=0.
REQ-037 alloc 3; next cycle rbusy for raddr=3 is 1; write 3 with 0x33 -> rbusy 0 that cycle, busy_o[3]=0 next; alloc+write 3 together -> busy_o[3]=1.
REQ-038 alloc 4, 9 then flush_i with alloc 6 -> busy_o all 0; rst_n low mid-write to 8 -> register 8 reads 0.
